// File: rtl/adc_scan_pkg.sv
// Shared types and sizes for the ADC scan sequencer.
package adc_scan_pkg;

  localparam int NUM_CH = 8;
  localparam int ADC_W  = 12;
  localparam int ACC_W  = 14;
  localparam int CH_W   = 3;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    WAIT_PRIME,
    ISSUE,
    WAIT_DONE,
    STORE
  } state_e;

endpackage

// File: rtl/adc_scan_sequencer_next_ch.sv
// Channel advance helper: next enabled channel above index (wrapping),
// and whether index is the highest enabled channel.
module adc_next_ch
  import adc_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [CH_W-1:0]   index_i,
  output logic [CH_W-1:0]   next_o,
  output logic              last_o
);

  logic            found;
  logic [CH_W-1:0] cand;

  // Search upward from index+1, wrapping; falls back to index itself.
  always_comb begin
    next_o = index_i;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k < NUM_CH; k++) begin
      cand = index_i + CH_W'(k);
      if (!found && mask_i[cand]) begin
        next_o = cand;
        found  = 1'b1;
      end
    end
  end

  assign last_o = ((mask_i >> ({1'b0, index_i} + 4'd1)) == '0);

endmodule

// File: rtl/adc_scan_sequencer.sv
// Periodic channel scanner for the ADC128S102 frame driver.
// The converter returns data one frame late, so each scan opens with a
// discarded prime frame. Optional build macro ADC_IIR_EN adds a per-channel
// first-order smoothing filter (x4 accumulator, alpha = 1/4).
module adc_scan_sequencer #(
  parameter int SCAN_PERIOD = 20000,
  parameter int TIMEOUT     = 63,
  parameter int NUM_CH      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scan_en_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  output logic              adc_start_o,
  output logic [2:0]        adc_channel_o,
  input  logic              adc_done_i,
  input  logic [11:0]       adc_data_i,
  input  logic [2:0]        rd_addr_i,
  output logic [11:0]       rd_data_o,
  output logic [NUM_CH-1:0] valid_mask_o,
  output logic              scan_done_o,
  output logic              timeout_err_o
);

  import adc_scan_pkg::*;

  localparam int PW = $clog2(SCAN_PERIOD);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     per_q;
  logic              tick;
  logic [TW-1:0]     tmo_q;
  logic              tmo_hit, tmo_abort;
  logic [NUM_CH-1:0] mask_q, mask_d, adv_mask;
  logic [CH_W-1:0]   cur_q, cur_d, prev_q, prev_d, adv_idx, adv_next;
  logic              last_q, last_d, adv_last;
  logic [ADC_W-1:0]  data_q, data_d, wr_data, rd_data_q;
  logic [ADC_W-1:0]  res_q [NUM_CH];
  logic [NUM_CH-1:0] valid_q;
  logic              wr_en, issue;
  logic              adc_start_q, scan_done_q, scan_done_d, timeout_err_q;
  logic [CH_W-1:0]   adc_channel_q;

  // Scan period counter; its wrap cycle is the scan tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  per_q <= '0;
    else if (!scan_en_i || tick) per_q <= '0;
    else                         per_q <= per_q + 1'b1;
  end

  assign tick = scan_en_i && (per_q == PW'(SCAN_PERIOD - 1));

  // Cycles since the last start pulse; saturates so it cannot wrap back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              tmo_q <= '0;
    else if (adc_start_q)    tmo_q <= TW'(1);
    else if (tmo_q != '1)    tmo_q <= tmo_q + 1'b1;
  end

  // The start cycle itself holds a stale count, hence the guard.
  assign tmo_hit = !adc_start_q && (tmo_q == TW'(TIMEOUT - 1));

  // In IDLE the helper finds the first channel of the incoming mask.
  assign adv_mask = (state_q == IDLE) ? ch_mask_i : mask_q;
  assign adv_idx  = (state_q == IDLE) ? CH_W'(NUM_CH - 1) : cur_q;

  adc_next_ch u_adv (
    .mask_i  (adv_mask),
    .index_i (adv_idx),
    .next_o  (adv_next),
    .last_o  (adv_last)
  );

  // Sequencer state and scan bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mask_q        <= '0;
      cur_q         <= '0;
      prev_q        <= '0;
      last_q        <= 1'b0;
      data_q        <= '0;
      adc_start_q   <= 1'b0;
      adc_channel_q <= '0;
      scan_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      last_q      <= last_d;
      data_q      <= data_d;
      adc_start_q <= issue;
      if (issue) adc_channel_q <= cur_q;
      scan_done_q <= scan_done_d;
      if (tmo_abort) timeout_err_q <= 1'b1;
    end
  end

  assign issue = (state_q == PRIME) || (state_q == ISSUE);

  // Next-state logic. last_q records whether prev is the top enabled
  // channel, captured when prev takes over cur's value.
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    cur_d       = cur_q;
    prev_d      = prev_q;
    last_d      = last_q;
    data_d      = data_q;
    wr_en       = 1'b0;
    scan_done_d = 1'b0;
    tmo_abort   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          mask_d = ch_mask_i;
          if (ch_mask_i != '0) begin
            cur_d   = adv_next;
            state_d = PRIME;
          end
        end
      end
      PRIME: state_d = WAIT_PRIME;
      WAIT_PRIME: begin
        if (adc_done_i) begin
          if (scan_en_i) begin
            prev_d  = cur_q;
            last_d  = adv_last;
            cur_d   = adv_next;
            state_d = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_d   = IDLE;
        end
      end
      ISSUE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (adc_done_i) begin
          data_d  = adc_data_i;
          state_d = STORE;
        end else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_d   = IDLE;
        end
      end
      STORE: begin
        wr_en = 1'b1;
        if (last_q || !scan_en_i) begin
          scan_done_d = last_q && scan_en_i;
          state_d     = IDLE;
        end else begin
          prev_d  = cur_q;
          last_d  = adv_last;
          cur_d   = adv_next;
          state_d = ISSUE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ADC_IIR_EN
  logic [ACC_W-1:0] acc_q [NUM_CH];
  logic [ACC_W-1:0] acc_d;

  // First sample seeds the accumulator; later ones blend in at 1/4.
  always_comb begin
    acc_d = {data_q, 2'b00};
    if (valid_q[prev_q])
      acc_d = acc_q[prev_q] - (acc_q[prev_q] >> 2) + ACC_W'(data_q);
  end

  assign wr_data = acc_d[ACC_W-1:2];

  // Per-channel accumulators, updated alongside the result file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_q <= '{default: '0};
    else if (wr_en) acc_q[prev_q] <= acc_d;
  end
`else
  assign wr_data = data_q;
`endif

  // Result file with registered read port; same-cycle read sees old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q     <= '{default: '0};
      valid_q   <= '0;
      rd_data_q <= '0;
    end else begin
      rd_data_q <= res_q[rd_addr_i];
      if (wr_en) begin
        res_q[prev_q]   <= wr_data;
        valid_q[prev_q] <= 1'b1;
      end
    end
  end

  assign adc_start_o   = adc_start_q;
  assign adc_channel_o = adc_channel_q;
  assign rd_data_o     = rd_data_q;
  assign valid_mask_o  = valid_q;
  assign scan_done_o   = scan_done_q;
  assign timeout_err_o = timeout_err_q;

endmodule
